// File: rtl/pattern_detector_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pattern_detector_pkg
// Purpose  : Shared limits, types and elaboration-time helper functions for
//            the serial pattern detector. The helpers build the detector's
//            transition table from the pattern value.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pattern_detector_pkg;

  localparam int MAX_LEN   = 16;
  localparam int MAX_CNT_W = 16;

  typedef enum logic {
    OVL_OFF = 1'b0,
    OVL_ON  = 1'b1
  } ovl_mode_e;

  // Next matched-prefix length after receiving bit b while in prefix k.
  // The candidate string s is the first k pattern bits followed by b.
  // Returns len when s completes the pattern, otherwise the longest suffix
  // of s (shorter than len) that is also a prefix of the pattern.
  function automatic int next_k(input logic [MAX_LEN-1:0] pattern,
                                input int len, input int k, input logic b);
    int pat;
    int s;
    int res;
    int top;
    pat = int'(pattern);
    s   = ((pat >> (len - k)) << 1) | int'(b);
    res = 0;
    if ((k + 1 == len) && (s == pat)) begin
      res = len;
    end else begin
      top = (k + 1 < len) ? k + 1 : len - 1;
      // Scan from longest to shortest; the first hit wins.
      for (int j = top; j > 0; j--) begin
        if ((res == 0) && ((s & ((1 << j) - 1)) == (pat >> (len - j))))
          res = j;
      end
    end
    return res;
  endfunction

  // Longest proper suffix of the pattern that is also its prefix; this is
  // the resume point after a match when overlapping detection is selected.
  function automatic int overlap_k(input logic [MAX_LEN-1:0] pattern,
                                   input int len);
    int pat;
    int res;
    pat = int'(pattern);
    res = 0;
    for (int j = len - 1; j > 0; j--) begin
      if ((res == 0) && ((pat & ((1 << j) - 1)) == (pat >> (len - j))))
        res = j;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pattern_detector_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Falling-edge saturating up-counter with synchronous clear and
//            asynchronous active-high reset. Holds at all-ones, never wraps.
// Ports    : clk (in)  clock, falling edge active
//            rst (in)  asynchronous active-high reset
//            clr (in)  synchronous clear, priority over inc
//            inc (in)  increment request
//            q   (out) W-bit count
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign q = cnt_q;

endmodule
`default_nettype wire

// File: rtl/pattern_detector.sv
`default_nettype none
// ============================================================================
// Module   : pattern_detector
// Purpose  : Serial bit-pattern detector. Tracks the longest matched prefix
//            of PATTERN (MSB first) and pulses match for one cycle on every
//            occurrence, with overlapping or non-overlapping detection.
//            All state changes on the falling edge of clk.
// Ports    : clk     (in)  clock, falling edge active
//            rst     (in)  asynchronous active-high reset
//            en      (in)  sample enable for din
//            din     (in)  serial data bit
//            overlap (in)  1 = overlapping, 0 = non-overlapping detection
//            clr     (in)  synchronous clear of state, match and count
//            match   (out) registered one-cycle match pulse
//            state   (out) current matched-prefix length, 0..LEN-1
//            count   (out) saturating match count
// Config   : PATTERN_DETECTOR_COUNT_EN builds the match counter; without it
//            count is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module pattern_detector #(
  parameter int             LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = 4'b1011,
  parameter int             CNT_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    din,
  input  logic                    overlap,
  input  logic                    clr,
  output logic                    match,
  output logic [$clog2(LEN)-1:0]  state,
  output logic [CNT_W-1:0]        count
);

  import pattern_detector_pkg::*;

  localparam int                 SW      = $clog2(LEN);
  localparam logic [MAX_LEN-1:0] PAT_EXT = MAX_LEN'(PATTERN);
  localparam int                 OVL_K   = overlap_k(PAT_EXT, LEN);

  // Transition table, one entry per prefix length and input bit value.
  // tbl_m* flags that the bit completes the pattern; tbl_k* is the next
  // prefix length when it does not.
  logic [SW-1:0]  tbl_k0 [LEN];
  logic [SW-1:0]  tbl_k1 [LEN];
  logic [LEN-1:0] tbl_m0;
  logic [LEN-1:0] tbl_m1;

  for (genvar g = 0; g < LEN; g++) begin : g_tbl
    localparam int NK0 = next_k(PAT_EXT, LEN, g, 1'b0);
    localparam int NK1 = next_k(PAT_EXT, LEN, g, 1'b1);
    assign tbl_m0[g] = (NK0 == LEN);
    assign tbl_m1[g] = (NK1 == LEN);
    assign tbl_k0[g] = (NK0 == LEN) ? '0 : SW'(NK0);
    assign tbl_k1[g] = (NK1 == LEN) ? '0 : SW'(NK1);
  end

  logic [SW-1:0] state_q, state_d;
  logic          match_q, match_d;
  logic          hit;
  logic [SW-1:0] nk;

  always_comb begin
    hit     = din ? tbl_m1[state_q] : tbl_m0[state_q];
    nk      = din ? tbl_k1[state_q] : tbl_k0[state_q];
    state_d = state_q;
    match_d = 1'b0;
    if (clr) begin
      state_d = '0;
    end else if (en) begin
      if (hit) begin
        match_d = 1'b1;
        state_d = (ovl_mode_e'(overlap) == OVL_ON) ? SW'(OVL_K) : '0;
      end else begin
        state_d = nk;
      end
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
    end
  end

  assign state = state_q;
  assign match = match_q;

`ifdef PATTERN_DETECTOR_COUNT_EN
  // match_d is already forced low under clr, and clr also zeroes the count.
  sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (match_d),
    .q   (count)
  );
`else
  assign count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pattern_detector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pattern_detector
// Purpose  : Self-checking bench for pattern_detector. Two instances share
//            the input stream: A (LEN=4, PATTERN=1011, CNT_W=8) and
//            B (LEN=4, PATTERN=1111, CNT_W=2). Expected outputs come from a
//            bit-history reference model and are checked by a monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pattern_detector;

`ifdef PATTERN_DETECTOR_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, en, din, overlap, clr;
  logic       a_match, b_match;
  logic [1:0] a_state, b_state;
  logic [7:0] a_count;
  logic [1:0] b_count;

  always #5 clk = ~clk;

  pattern_detector #(.LEN(4), .PATTERN(4'b1011), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .en(en), .din(din), .overlap(overlap), .clr(clr),
    .match(a_match), .state(a_state), .count(a_count)
  );

  pattern_detector #(.LEN(4), .PATTERN(4'b1111), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .en(en), .din(din), .overlap(overlap), .clr(clr),
    .match(b_match), .state(b_state), .count(b_count)
  );

  typedef struct {
    int as; int am; int ac;
    int bs; int bm; int bc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: the last accepted bits (up to 4) as an integer plus
  // their count, and the match tally per instance.
  int hv[2];
  int hl[2];
  int cnt[2];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      hv[i] = 0; hl[i] = 0; cnt[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input int pat, input int cw,
                            input logic e, input logic d, input logic o, input logic c,
                            output int st, output int m, output int ct);
    m = 0;
    if (c) begin
      hv[i] = 0; hl[i] = 0; cnt[i] = 0;
    end else if (e) begin
      hv[i] = ((hv[i] << 1) | int'(d)) & 15;
      if (hl[i] < 4) hl[i]++;
      if (hl[i] == 4 && hv[i] == pat) begin
        m = 1;
        if (cnt[i] < (1 << cw) - 1) cnt[i]++;
        if (!o) begin hv[i] = 0; hl[i] = 0; end
      end
    end
    // Longest tail of the history (shorter than the pattern) equal to a
    // leading piece of the pattern.
    st = 0;
    for (int j = 3; j >= 1; j--)
      if (st == 0 && j <= hl[i] && (hv[i] & ((1 << j) - 1)) == (pat >> (4 - j)))
        st = j;
    ct = CNT_ON ? cnt[i] : 0;
  endtask

  task automatic step(input logic e, input logic d, input logic o, input logic c);
    exp_t x;
    @(posedge clk); #2;
    en = e; din = d; overlap = o; clr = c;
    model_step(0, 11, 8, e, d, o, c, x.as, x.am, x.ac);
    model_step(1, 15, 2, e, d, o, c, x.bs, x.bm, x.bc);
    sb.push_back(x);
  endtask

  // Let the last step be checked, then park the inputs so idle edges
  // change nothing.
  task automatic settle();
    @(posedge clk); #1;
    en = 1'b0; clr = 1'b0;
  endtask

  // Monitor: outputs settle on the falling edge, sampled on the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("a_state", 32'(a_state), e.as);
        chk("a_match", 32'(a_match), e.am);
        chk("a_count", 32'(a_count), e.ac);
        chk("b_state", 32'(b_state), e.bs);
        chk("b_match", 32'(b_match), e.bm);
        chk("b_count", 32'(b_count), e.bc);
      end
    end
  end

  initial begin
    logic [6:0] s7;
    logic [3:0] s4;
    rst = 1'b1; en = 1'b0; din = 1'b0; overlap = 1'b0; clr = 1'b0;
    model_reset();
    #1;
    chk("rst_a_state", 32'(a_state), 0);
    chk("rst_a_match", 32'(a_match), 0);
    chk("rst_a_count", 32'(a_count), 0);
    chk("rst_b_count", 32'(b_count), 0);
    @(posedge clk); #2;
    rst = 1'b0;

    // Overlapping detection of 1011 in 1011011
    s7 = 7'b1011011;
    for (int i = 6; i >= 0; i--) step(1'b1, s7[i], 1'b1, 1'b0);
    settle();
    chk("ovl_match", 32'(a_match), 1);
    chk("ovl_count", 32'(a_count), CNT_ON ? 2 : 0);

    // Non-overlapping detection of the same stream
    step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 6; i >= 0; i--) step(1'b1, s7[i], 1'b0, 1'b0);
    settle();
    chk("novl_match", 32'(a_match), 0);
    chk("novl_state", 32'(a_state), 1);
    chk("novl_count", 32'(a_count), CNT_ON ? 1 : 0);

    // Enable gap between bits 2 and 3
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    settle();
    chk("gap_match", 32'(a_match), 1);

    // Saturation of the 2-bit counter on instance B with 1111
    step(1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    settle();
    chk("sat_b_match", 32'(b_match), 1);
    chk("sat_b_state", 32'(b_state), 3);
    chk("sat_b_count", 32'(b_count), CNT_ON ? 3 : 0);

    // Clear on the edge that would complete 1011
    step(1'b1, 1'b0, 1'b1, 1'b1);
    s7 = 7'b1011011;
    for (int i = 6; i >= 1; i--) step(1'b1, s7[i], 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    settle();
    chk("clr_match", 32'(a_match), 0);
    chk("clr_state", 32'(a_state), 0);
    chk("clr_count", 32'(a_count), 0);

    // Asynchronous reset in the middle of a partial match
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    settle();
    #2 rst = 1'b1;
    #1;
    chk("arst_state", 32'(a_state), 0);
    chk("arst_match", 32'(a_match), 0);
    chk("arst_count", 32'(a_count), 0);
    model_reset();
    @(posedge clk); #2;
    rst = 1'b0;
    s4 = 4'b1011;
    for (int i = 3; i >= 0; i--) step(1'b1, s4[i], 1'b0, 1'b0);
    settle();
    chk("arst_after_match", 32'(a_match), 1);
    chk("arst_after_count", 32'(a_count), CNT_ON ? 1 : 0);

    // Randomised stream
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), $urandom_range(0, 40) == 0);
    end
    settle();
    chk("sb_drain", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
